// File: rtl/bus_requester.sv
// Bus requester: queues burst commands, requests the arbiter per command, streams beats seed+i once granted.
// Grant-to-first-beat latency is 1 cycle; cmd_ready drops when the FIFO is full, and a dropped grant stalls the burst.
module bus_requester #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 4,
  parameter int DATA_W     = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_seed,
  output logic              req,
  input  logic              grant,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              done,
  output logic              timeout_err,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] seed;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

  state_t            state_q, state_d;
  cmd_t              fifo_q [FIFO_DEPTH];
  cmd_t              fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  cmd_t              cmd_q, cmd_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              req_q, req_d;
  logic              bus_valid_q, bus_valid_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic              bus_last_q, bus_last_d;
  logic              done_q, done_d;
  logic              timeout_err_q, timeout_err_d;
  logic              busy_q, busy_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              push, pop, emit;

  always_comb begin
    state_d       = state_q;
    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cmd_d         = cmd_q;
    beat_cnt_d    = beat_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    req_d         = req_q;
    bus_valid_d   = 1'b0;
    bus_data_d    = bus_data_q;
    bus_last_d    = 1'b0;
    done_d        = 1'b0;
    timeout_err_d = 1'b0;
    push          = cmd_valid && cmd_ready_q;
    pop           = 1'b0;
    emit          = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          cmd_d      = fifo_q[rd_ptr_q];
          beat_cnt_d = '0;
          wait_cnt_d = '0;
          req_d      = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (grant) begin
          emit    = 1'b1;
          state_d = XFER;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
          if (wait_cnt_d == 8'(TIMEOUT)) begin
            req_d         = 1'b0;
            timeout_err_d = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      XFER: begin
        // The last beat is already on the bus, so this cycle's grant is irrelevant.
        if (bus_valid_q && bus_last_q) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = RELEASE;
        end else if (grant) begin
          emit = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (emit) begin
      bus_valid_d = 1'b1;
      bus_data_d  = cmd_q.seed + DATA_W'(beat_cnt_q);
      bus_last_d  = (beat_cnt_q == cmd_q.len);
      beat_cnt_d  = beat_cnt_q + LEN_W'(1);
    end

    if (push) begin
      fifo_d[wr_ptr_q] = '{len: cmd_len, seed: cmd_seed};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    cmd_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    busy_d      = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cmd_q         <= '0;
      beat_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      req_q         <= 1'b0;
      bus_valid_q   <= 1'b0;
      bus_data_q    <= '0;
      bus_last_q    <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      cmd_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      fifo_q        <= fifo_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      cmd_q         <= cmd_d;
      beat_cnt_q    <= beat_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      req_q         <= req_d;
      bus_valid_q   <= bus_valid_d;
      bus_data_q    <= bus_data_d;
      bus_last_q    <= bus_last_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign req         = req_q;
  assign bus_valid   = bus_valid_q;
  assign bus_data    = bus_data_q;
  assign bus_last    = bus_last_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_bus_requester.sv
// Directed bench for bus_requester: expected beats are queued at command push and checked as beats appear.
module tb_bus_requester;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_len;
  logic [7:0] cmd_seed;
  logic       req;
  logic       grant;
  logic       bus_valid;
  logic [7:0] bus_data;
  logic       bus_last;
  logic       done;
  logic       timeout_err;
  logic       busy;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    checks = 0;
  int    errors = 0;
  bit    gpat [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  bus_requester #(
    .FIFO_DEPTH(4),
    .LEN_W     (4),
    .DATA_W    (8),
    .TIMEOUT   (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_seed   (cmd_seed),
    .req        (req),
    .grant      (grant),
    .bus_valid  (bus_valid),
    .bus_data   (bus_data),
    .bus_last   (bus_last),
    .done       (done),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every bus beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", 32'(bus_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_data", 32'(bus_data), 32'(mon_e.data));
        chk("beat_last", 32'(bus_last), 32'(mon_e.last));
      end
    end
  end

  task automatic push_cmd(input logic [3:0] len, input logic [7:0] seed, input int nexp);
    int w = 0;
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_seed  = seed;
    while (cmd_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("push_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    for (int i = 0; i < nexp; i++) begin
      beat_t b;
      b.data = seed + 8'(i);
      b.last = (i == int'(len));
      exp_q.push_back(b);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int w = 0;
    while (req !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk(tag, 32'(req), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int dones;
    int low_run;
    logic prev_req;

    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_seed  = '0;
    grant     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_bus_last", 32'(bus_last), 32'd0);
    chk("rst_bus_data", 32'(bus_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);

    // Single beat, immediate grant.
    push_cmd(4'd0, 8'hA5, 1);
    wait_req("t1_req");
    grant = 1'b1;
    @(negedge clk);
    chk("t1_valid", 32'(bus_valid), 32'd1);
    chk("t1_req_during_beat", 32'(req), 32'd1);
    grant = 1'b0;
    @(negedge clk);
    chk("t1_req_released", 32'(req), 32'd0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_valid_after", 32'(bus_valid), 32'd0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 32'd0);

    // Four beats with a three-cycle grant gap; data wraps past FF.
    push_cmd(4'd3, 8'hFE, 4);
    wait_req("t2_req");
    for (int i = 0; i < 7; i++) begin
      grant = gpat[i];
      @(negedge clk);
      chk("t2_valid", 32'(bus_valid), 32'(gpat[i]));
      chk("t2_req_held", 32'(req), 32'd1);
    end
    grant = 1'b0;
    @(negedge clk);
    chk("t2_req_released", 32'(req), 32'd0);
    chk("t2_done", 32'(done), 32'd1);

    // Timeout with grant held low.
    push_cmd(4'd2, 8'h10, 0);
    wait_req("t3_req");
    hi = 1;
    while (req === 1'b1 && hi < 40) begin
      @(negedge clk);
      if (req === 1'b1) hi++;
    end
    chk("t3_req_cycles", 32'(hi), 32'd15);
    chk("t3_timeout_err", 32'(timeout_err), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t3_timeout_pulse", 32'(timeout_err), 32'd0);

    // Fill the FIFO behind one popped command, then grant continuously.
    push_cmd(4'd1, 8'h10, 2);
    push_cmd(4'd0, 8'h20, 1);
    push_cmd(4'd2, 8'hF0, 3);
    push_cmd(4'd15, 8'h80, 16);
    push_cmd(4'd3, 8'h33, 4);
    chk("t4_full_ready", 32'(cmd_ready), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    grant    = 1'b1;
    dones    = 0;
    low_run  = 0;
    prev_req = req;
    for (int c = 0; c < 400 && dones < 5; c++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (req === 1'b1) begin
        if (prev_req !== 1'b1) chk("t4_req_gap", 32'(low_run), 32'd2);
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_req = req;
    end
    grant = 1'b0;
    chk("t4_bursts_done", 32'(dones), 32'd5);
    chk("t4_ready_after", 32'(cmd_ready), 32'd1);

    // Reset during beat 2 of an eight-beat burst.
    push_cmd(4'd7, 8'h40, 3);
    wait_req("t5_req");
    grant = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t5_req_async", 32'(req), 32'd0);
    chk("t5_valid_async", 32'(bus_valid), 32'd0);
    chk("t5_data_async", 32'(bus_data), 32'd0);
    chk("t5_done_async", 32'(done), 32'd0);
    chk("t5_busy_async", 32'(busy), 32'd0);
    grant = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_req_quiet", 32'(req), 32'd0);
    chk("t5_busy_quiet", 32'(busy), 32'd0);
    chk("t5_ready", 32'(cmd_ready), 32'd1);

    // Stray grant while idle with an empty FIFO.
    grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_valid", 32'(bus_valid), 32'd0);
      chk("t6_req", 32'(req), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
    end
    grant = 1'b0;

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_requester.md
Name: bus_requester

Overview:
Master-side endpoint of the req/grant bus arbitration interface. It is the requester that drives one `req` bit into `bus_arbiter` and consumes the matching `grant` bit. Local logic queues burst commands into a small FIFO. The block arbitrates for the bus per command, streams the burst once granted, then releases the bus so round-robin rotation can proceed.

Parameters:
- FIFO_DEPTH, 4: command FIFO entries; must be a power of two, minimum 2.
- LEN_W, 4: width of the burst-length field; a burst is cmd_len+1 beats (1..16).
- DATA_W, 8: bus data width.
- TIMEOUT, 15: maximum number of cycles spent in REQ without grant before the command is abandoned; range 1..255.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset. All state clears while low.
- cmd_valid, input, 1: a command is offered.
- cmd_ready, output, 1: FIFO not full. A push occurs when cmd_valid && cmd_ready.
- cmd_len, input, LEN_W: beats minus one.
- cmd_seed, input, DATA_W: data value for beat 0.
- req, output, 1: bus request to the arbiter.
- grant, input, 1: grant from the arbiter for this requester.
- bus_valid, output, 1: a beat is on the bus this cycle.
- bus_data, output, DATA_W: beat data, equal to cmd_seed + beat_index, modulo 2^DATA_W.
- bus_last, output, 1: final beat of the burst; qualified by bus_valid.
- done, output, 1: one-cycle pulse when a burst completes.
- timeout_err, output, 1: one-cycle pulse when a command is abandoned.
- busy, output, 1: FSM is not in IDLE, or the FIFO is non-empty.

Behaviour:
- Reset values: req=0, bus_valid=0, bus_last=0, bus_data=0, done=0, timeout_err=0, busy=0, cmd_ready=1, FIFO empty, FSM in IDLE, all counters 0.
- All outputs are registered. There is no combinational path from grant to any output.
- FIFO push and pop in the same cycle are both honoured. A push when full is ignored because cmd_ready=0. FIFO pointers wrap modulo FIFO_DEPTH.
- IDLE:
  - If the FIFO is non-empty, pop the head, latch len/seed, clear beat_cnt and wait_cnt, and go to REQ.
  - req rises on the cycle after the pop.
- REQ (req=1):
  - Each cycle with grant=0, wait_cnt increments.
  - Sampling grant=1 moves the FSM to XFER. The first beat (bus_valid=1) appears on the next cycle, i.e. grant-to-first-beat latency is 1 cycle.
  - When wait_cnt reaches TIMEOUT with grant still 0: drop req, pulse timeout_err, discard the command, return to IDLE.
  - If grant and timeout coincide in the same cycle, grant wins.
- XFER (req=1):
  - While grant=1: bus_valid=1, bus_data=seed+beat_cnt, and beat_cnt increments.
  - If grant drops mid-burst: bus_valid=0 from the next cycle, beat_cnt holds, req stays 1, and the burst resumes at the same beat when grant returns. TIMEOUT does not apply in XFER.
  - bus_last=1 on the beat where beat_cnt == len. After that beat the FSM goes to RELEASE.
- RELEASE:
  - req=0 and bus_valid=0 for exactly one cycle; done pulses in this cycle.
  - Then IDLE. req is therefore low for at least 2 cycles between back-to-back commands (RELEASE + IDLE).
- A grant seen while req=0 (in IDLE or RELEASE) is ignored; no beat is driven.
- Reset asserted mid-burst: outputs return to reset values immediately (asynchronously). Queued and in-flight commands are lost.
- busy reflects a registered FSM state and a FIFO-empty flag.

Test Plan:
- Single beat, immediate grant: push len=0, seed=8'hA5. When req=1, drive grant=1 → exactly one beat with bus_data=A5 and bus_last=1, one cycle after the grant is sampled. Then req=0 and done=1 in the same cycle.
- 4-beat burst with a grant gap: len=3, seed=8'hFE. Grant is high for 2 cycles, low for 3, then high → bus_data sequence FE, FF, 00, 01 (wrap). bus_valid=0 during the gap. bus_last only on 01. req stays high throughout.
- Timeout: push len=2 and hold grant=0 → req high for 15 cycles, then req=0 and a timeout_err pulse. No bus_valid at any point. busy=0 afterwards.
- FIFO full and back-to-back: push 5 commands without grant → cmd_ready=0 after 4 FIFO entries plus 1 popped (the 5th push is accepted only after the first pop). Granting continuously produces 5 bursts, each separated by at least 2 cycles of req=0.
- Reset mid-burst: during beat 2 of a len=7 burst, pull reset low → req, bus_valid, done and busy go to 0 immediately. After release, no beats are emitted without a new push.
- Stray grant: grant=1 in IDLE with an empty FIFO → no bus_valid, req=0, busy=0.
